// File: rtl/id_r_encoder.sv
// Packs an internal op code and register fields into a MIPS SPECIAL/SPECIAL2 word
// and buffers the result in a small valid/ready FIFO; unencodable ops are dropped and counted.
module id_r_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op,
    input  logic [4:0]       reg_s,
    input  logic [4:0]       reg_t,
    input  logic [4:0]       reg_d,
    input  logic [4:0]       shift,
    input  logic             flag_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    // Internal op codes, mirroring the `OP_* values of defs.v
    localparam logic [7:0] OP_INVAILD = 8'd0;
    localparam logic [7:0] OP_SLL     = 8'd1;
    localparam logic [7:0] OP_SRL     = 8'd2;
    localparam logic [7:0] OP_SRA     = 8'd3;
    localparam logic [7:0] OP_SLLV    = 8'd4;
    localparam logic [7:0] OP_SRLV    = 8'd5;
    localparam logic [7:0] OP_SRAV    = 8'd6;
    localparam logic [7:0] OP_JR      = 8'd7;
    localparam logic [7:0] OP_JALR    = 8'd8;
    localparam logic [7:0] OP_MOVZ    = 8'd9;
    localparam logic [7:0] OP_MOVN    = 8'd10;
    localparam logic [7:0] OP_SYSCALL = 8'd11;
    localparam logic [7:0] OP_BREAK   = 8'd12;
    localparam logic [7:0] OP_SYNC    = 8'd13;
    localparam logic [7:0] OP_MFHI    = 8'd14;
    localparam logic [7:0] OP_MTHI    = 8'd15;
    localparam logic [7:0] OP_MFLO    = 8'd16;
    localparam logic [7:0] OP_MTLO    = 8'd17;
    localparam logic [7:0] OP_MULT    = 8'd18;
    localparam logic [7:0] OP_DIV     = 8'd19;
    localparam logic [7:0] OP_ADD     = 8'd20;
    localparam logic [7:0] OP_SUB     = 8'd21;
    localparam logic [7:0] OP_AND     = 8'd22;
    localparam logic [7:0] OP_OR      = 8'd23;
    localparam logic [7:0] OP_XOR     = 8'd24;
    localparam logic [7:0] OP_NOR     = 8'd25;
    localparam logic [7:0] OP_SLT     = 8'd26;
    localparam logic [7:0] OP_MADD    = 8'd27;
    localparam logic [7:0] OP_MUL     = 8'd28;
    localparam logic [7:0] OP_MSUB    = 8'd29;
    localparam logic [7:0] OP_CLZ     = 8'd30;
    localparam logic [7:0] OP_CLO     = 8'd31;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1c;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             legal;
    logic [31:0]      word;
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             accept;
    logic             do_push;
    logic             do_pop;

    // Op to opcode/funct lookup; paired entries pick the unsigned funct on flag_unsigned
    always_comb begin
        opcode = OPC_SPECIAL;
        funct  = 6'h00;
        legal  = 1'b1;
        case (op)
            OP_SLL:     funct = 6'h00;
            OP_SRL:     funct = 6'h02;
            OP_SRA:     funct = 6'h03;
            OP_SLLV:    funct = 6'h04;
            OP_SRLV:    funct = 6'h06;
            OP_SRAV:    funct = 6'h07;
            OP_JR:      funct = 6'h08;
            OP_JALR:    funct = 6'h09;
            OP_MOVZ:    funct = 6'h0a;
            OP_MOVN:    funct = 6'h0b;
            OP_SYSCALL: funct = 6'h0c;
            OP_BREAK:   funct = 6'h0d;
            OP_SYNC:    funct = 6'h0f;
            OP_MFHI:    funct = 6'h10;
            OP_MTHI:    funct = 6'h11;
            OP_MFLO:    funct = 6'h12;
            OP_MTLO:    funct = 6'h13;
            OP_MULT:    funct = flag_unsigned ? 6'h19 : 6'h18;
            OP_DIV:     funct = flag_unsigned ? 6'h1b : 6'h1a;
            OP_ADD:     funct = flag_unsigned ? 6'h21 : 6'h20;
            OP_SUB:     funct = flag_unsigned ? 6'h23 : 6'h22;
            OP_AND:     funct = 6'h24;
            OP_OR:      funct = 6'h25;
            OP_XOR:     funct = 6'h26;
            OP_NOR:     funct = 6'h27;
            OP_SLT:     funct = flag_unsigned ? 6'h2b : 6'h2a;
            OP_MADD: begin
                opcode = OPC_SPECIAL2;
                funct  = flag_unsigned ? 6'h01 : 6'h00;
            end
            OP_MUL: begin
                opcode = OPC_SPECIAL2;
                funct  = 6'h02;
            end
            OP_MSUB: begin
                opcode = OPC_SPECIAL2;
                funct  = flag_unsigned ? 6'h05 : 6'h04;
            end
            OP_CLZ: begin
                opcode = OPC_SPECIAL2;
                funct  = 6'h20;
            end
            OP_CLO: begin
                opcode = OPC_SPECIAL2;
                funct  = 6'h21;
            end
            OP_INVAILD: legal = 1'b0;
            default:    legal = 1'b0;
        endcase
    end

    assign word      = {opcode, reg_s, reg_t, reg_d, shift, funct};
    assign in_ready  = (occ != CNT_FULL);
    assign out_valid = (occ != '0);
    assign inst      = out_valid ? mem[rd_ptr] : 32'h0;
    assign accept    = in_valid && in_ready;
    assign do_push   = accept && legal && !flush;
    assign do_pop    = out_valid && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= word;
        end
    end

    // Flush wins over any push or pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // An illegal op is reported even when it coincides with a flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            err <= accept && !legal;
            if (do_push) begin
                enc_count <= enc_count + CNT_ONE;
            end
            if (accept && !legal) begin
                err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: doc/id_r_encoder.md
# id_r_encoder

Encoding counterpart of the R-type field decoder: packs an internal op code, register fields, shift amount and an unsigned flag into a 32-bit MIPS SPECIAL (opcode 0x00) or SPECIAL2 (opcode 0x1c) instruction word. It sits in the debug/self-test path and feeds an instruction injector. The block buffers encoded words in a small FIFO with valid/ready handshakes on both sides. It drops unencodable ops and counts them.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of both counters
- clk  in  1  clock, all state on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of the FIFO contents (counters are kept)
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- op  in  8  `OP_* code from defs.v
- reg_s, reg_t, reg_d, shift  in  5 each  field values
- flag_unsigned  in  1  selects the unsigned variant where one exists
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes the head word when out_valid && out_ready
- inst  out  32  encoded word at the FIFO head
- err  out  1  one-cycle pulse: an accepted op was unencodable
- enc_count  out  CNT_W  words pushed since reset, wraps modulo 2^CNT_W
- err_count  out  CNT_W  ops dropped since reset, wraps

## Operation
- Field placement is fixed and copied verbatim with no canonicalisation:
  - inst[25:21]=reg_s, inst[20:16]=reg_t, inst[15:11]=reg_d, inst[10:6]=shift.
  - inst[31:26] is the opcode; inst[5:0] is the funct.
- SPECIAL (opcode 0x00) funct map:
  - SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07
  - JR 08, JALR 09, MOVZ 0a, MOVN 0b, SYSCALL 0c, BREAK 0d, SYNC 0f
  - MFHI 10, MTHI 11, MFLO 12, MTLO 13
  - MULT 18/19, DIV 1a/1b, ADD 20/21, SUB 22/23
  - AND 24, OR 25, XOR 26, NOR 27, SLT 2a/2b
- SPECIAL2 (opcode 0x1c) funct map:
  - MADD 00/01, MUL 02, MSUB 04/05, CLZ 20, CLO 21
- For pairs x/y, flag_unsigned=1 selects y. For all other ops flag_unsigned is ignored.
- Any other op value, including `OP_INVAILD, is unencodable:
  - The request is still consumed (handshake completes) but nothing is pushed.
  - err pulses and err_count increments.
- On a valid encode: push the word, enc_count increments.
- FIFO: circular buffer with read/write pointers and an occupancy counter of width log2(DEPTH)+1.
  - in_ready = !full.
  - out_valid = !empty.
  - inst = mem[rd_ptr]; inst is 0 when empty.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and both pointers advance.
- Full: in_ready is low, so there is no push. No same-cycle bypass of a pop into a free slot.
- Empty: a push makes the word visible next cycle. There is no combinational in→out path.
- flush: clears the pointers and occupancy.
  - It beats a push and a pop in the same cycle; that push is discarded and not counted.
  - An unencodable op in the flush cycle still raises err and increments err_count.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_n low, asynchronous) gives:
  - in_ready=1, out_valid=0, inst=0, err=0, enc_count=0, err_count=0, FIFO empty.
- Latency: a request accepted at edge N appears on inst with out_valid=1 after edge N (1 cycle), provided the FIFO was empty.
- err is asserted for exactly the cycle following the accepting edge.
- Throughput: 1 word per cycle sustained when out_ready is held high.
- inst and out_valid hold stable while out_valid && !out_ready.
- Reset asserted mid-operation discards all buffered words immediately. The first edge after deassertion behaves as a fresh start.

## Test plan
- ADD, flag_unsigned=1, rs=1 rt=2 rd=3 sa=0 -> inst=0x00221821 one cycle later, enc_count=1.
- SLL, rt=5 rd=6 sa=4 -> 0x00053100. Then MUL rs=4 rt=5 rd=2 -> 0x70851002. Then CLZ rs=7 rd=8 -> 0x70e04020. All three appear in order.
- out_ready=0, push 4 ops (DEPTH=4) -> in_ready=0 after the 4th. A 5th held in_valid stalls. Raise out_ready -> 5 words drained in order, no loss.
- op=`OP_INVAILD with in_valid=1 -> in_ready=1, err pulses 1 cycle, err_count=1, out_valid stays 0.
- FIFO holding 2 words, flush together with in_valid (ADD) and out_ready -> next cycle out_valid=0, enc_count unchanged.
- Push 2 words, pulse rst_n low between edges -> outputs drop to reset values asynchronously, counters=0.
